// File: rtl/input_port_rc_if.sv
// Flit/route bundle between an input port, its link receiver, routing table and switch arbiter.
// "slave" is the input port side; "master" is the surrounding router/environment.
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif

interface input_port_rc_if #(
    parameter int unsigned FLIT_W = 16
);
    logic [FLIT_W-1:0]     in_flit;
    logic                  in_valid;
    logic                  in_ready;
    logic [`ADDR_BITS-1:0] table_addr;
    logic [`BITS_DIR-1:0]  table_data;
    logic [FLIT_W-1:0]     out_flit;
    logic [`BITS_DIR-1:0]  out_dir;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err;

    modport master (
        output in_flit, in_valid, table_data, out_ready,
        input  in_ready, table_addr, out_flit, out_dir, out_valid, err
    );

    modport slave (
        input  in_flit, in_valid, table_data, out_ready,
        output in_ready, table_addr, out_flit, out_dir, out_valid, err
    );
endinterface

// File: rtl/input_port_rc.sv
// Input port: small flit FIFO plus route computation that pins one output direction
// for a whole wormhole packet and forwards flits with a valid/ready handshake.
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif

module input_port_rc #(
    parameter int unsigned NODE_ID = 0,
    parameter int unsigned FLIT_W  = 16,
    parameter int unsigned DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    input_port_rc_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [`BITS_DIR-1:0] DIR_LOCAL = `BITS_DIR'(4);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [FLIT_W-1:0]    mem_q [DEPTH];
    logic [PTR_W:0]       wr_ptr_q;
    logic [PTR_W:0]       rd_ptr_q;
    state_t               state_q;
    state_t               state_d;
    logic [`BITS_DIR-1:0] route_q;
    logic [`BITS_DIR-1:0] route_d;
    logic                 err_q;
    logic                 err_d;

    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 out_valid;
    logic [FLIT_W-1:0]    head_flit;
    logic                 head_is_hdr;
    logic                 head_is_last;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push  = bus.in_valid && !full;

    // Head read is combinational and forced to zero when empty so outputs stay X-free.
    assign head_flit    = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_is_hdr  = head_flit[FLIT_W-2];
    assign head_is_last = head_flit[FLIT_W-1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= IDLE;
            route_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            state_q <= state_d;
            route_q <= route_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        err_d     = err_q;
        pop       = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (head_is_hdr) begin
                        route_d = bus.table_data;
                        state_d = ACTIVE;
                        if (bus.table_data > DIR_LOCAL) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        // Orphan body/tail with no route: discard it and flag.
                        pop   = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                out_valid = !empty;
                if (out_valid && bus.out_ready) begin
                    pop = 1'b1;
                    if (head_is_last) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    assign bus.in_ready   = !full;
    assign bus.table_addr = head_flit[`ADDR_BITS-1:0];
    assign bus.out_flit   = head_flit;
    assign bus.out_dir    = route_q;
    assign bus.out_valid  = out_valid;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_input_port_rc.sv
// Directed bench for input_port_rc at node 5 of a 4x4 mesh with an XY routing table.
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif

module tb_input_port_rc;
    typedef struct packed {
        logic [15:0] flit;
        logic [2:0]  dir;
        logic [31:0] cyc;
    } xfer_t;

    logic clk;
    logic reset;
    logic force6;
    int   checks;
    int   failures;
    int   cyc;
    xfer_t xq[$];
    logic [15:0] exp_f [8];
    logic [2:0]  exp_d [8];
    int          exp_c [8];

    input_port_rc_if #(.FLIT_W(16)) bus ();

    input_port_rc #(
        .NODE_ID(5),
        .FLIT_W (16),
        .DEPTH  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Node 5 sits at x=1, y=1 (id = 4*y + x); XY routing, x first.
    function automatic logic [2:0] xy_route(input logic [3:0] a);
        logic [1:0] dx;
        logic [1:0] dy;
        dx = a[1:0];
        dy = a[3:2];
        if (dx < 2'd1)      return 3'd3;
        else if (dx > 2'd1) return 3'd1;
        else if (dy < 2'd1) return 3'd0;
        else if (dy > 2'd1) return 3'd2;
        else                return 3'd4;
    endfunction

    always_comb bus.table_data = force6 ? 3'd6 : xy_route(bus.table_addr);

    function automatic logic [15:0] mk(input logic [1:0] t, input logic [3:0] d, input logic [9:0] p);
        return {t, p, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, log any transfer occurring at the coming edge, then settle.
    task automatic tick(input logic v, input logic [15:0] f, input logic rdy);
        xfer_t x;
        bus.in_valid  = v;
        bus.in_flit   = f;
        bus.out_ready = rdy;
        if (bus.out_valid && rdy) begin
            x.flit = bus.out_flit;
            x.dir  = bus.out_dir;
            x.cyc  = 32'(cyc);
            xq.push_back(x);
            $display("xfer cyc=%0d flit=0x%04h dir=%0d", cyc, bus.out_flit, bus.out_dir);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_test();
        xq.delete();
        cyc = 0;
    endtask

    task automatic set_exp(input int i, input logic [15:0] f, input logic [2:0] d, input int c);
        exp_f[i] = f;
        exp_d[i] = d;
        exp_c[i] = c;
    endtask

    task automatic check_stream(input string tag, input int n);
        check({tag, "_count"}, 32'(xq.size()), 32'(n));
        for (int i = 0; i < n && i < xq.size(); i++) begin
            check($sformatf("%s_flit%0d", tag, i), 32'(xq[i].flit), 32'(exp_f[i]));
            check($sformatf("%s_dir%0d", tag, i), 32'(xq[i].dir), 32'(exp_d[i]));
            check($sformatf("%s_cyc%0d", tag, i), xq[i].cyc, 32'(exp_c[i]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1'b0, 16'h0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_dir"}, 32'(bus.out_dir), 32'd0);
        check({tag, "_out_flit"}, 32'(bus.out_flit), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
        check({tag, "_table_addr"}, 32'(bus.table_addr), 32'd0);
    endtask

    initial begin
        logic [15:0] s1, h9, b9a, b9b, t9, s5, p0, p1, p2, p3, xm, bo, s9, h9r, b9r, h4, t4;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        force6   = 1'b0;
        reset    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_flit   = 16'h0;
        bus.out_ready = 1'b0;

        s1  = mk(2'b11, 4'd1, 10'h011);
        h9  = mk(2'b01, 4'd9, 10'h091);
        b9a = mk(2'b00, 4'd9, 10'h092);
        b9b = mk(2'b00, 4'd9, 10'h093);
        t9  = mk(2'b10, 4'd9, 10'h094);
        s5  = mk(2'b11, 4'd5, 10'h055);
        p0  = mk(2'b01, 4'd1, 10'h100);
        p1  = mk(2'b00, 4'd1, 10'h101);
        p2  = mk(2'b00, 4'd1, 10'h102);
        p3  = mk(2'b10, 4'd1, 10'h103);
        xm  = mk(2'b11, 4'd5, 10'h3AA);
        bo  = mk(2'b00, 4'd2, 10'h0B0);
        s9  = mk(2'b11, 4'd9, 10'h099);
        h9r = mk(2'b01, 4'd9, 10'h0C1);
        b9r = mk(2'b00, 4'd9, 10'h0C2);
        h4  = mk(2'b01, 4'd4, 10'h041);
        t4  = mk(2'b10, 4'd4, 10'h042);

        // Reset state
        do_reset();
        check_reset_outputs("rst");

        // Single flit dest 1: visible next cycle, valid two cycles after accept
        start_test();
        tick(1'b1, s1, 1'b1);
        check("single_addr", 32'(bus.table_addr), 32'd1);
        check("single_nv", 32'(bus.out_valid), 32'd0);
        tick(1'b0, 16'h0, 1'b1);
        check("single_v", 32'(bus.out_valid), 32'd1);
        check("single_flit", 32'(bus.out_flit), 32'(s1));
        check("single_dir", 32'(bus.out_dir), 32'd0);
        tick(1'b0, 16'h0, 1'b1);
        check("single_idle_v", 32'(bus.out_valid), 32'd0);
        check("single_idle_addr", 32'(bus.table_addr), 32'd0);
        set_exp(0, s1, 3'd0, 2);
        check_stream("single", 1);

        // 4-flit packet south then single local: streaming, then one-cycle bubble
        start_test();
        tick(1'b1, h9, 1'b1);
        tick(1'b1, b9a, 1'b1);
        tick(1'b1, b9b, 1'b1);
        tick(1'b1, t9, 1'b1);
        tick(1'b1, s5, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 16'h0, 1'b1);
        set_exp(0, h9, 3'd2, 2);
        set_exp(1, b9a, 3'd2, 3);
        set_exp(2, b9b, 3'd2, 4);
        set_exp(3, t9, 3'd2, 5);
        set_exp(4, s5, 3'd4, 7);
        check_stream("pkt", 5);

        // Backpressure: fill FIFO, extra flit ignored even while popping
        start_test();
        tick(1'b1, p0, 1'b0);
        tick(1'b1, p1, 1'b0);
        tick(1'b1, p2, 1'b0);
        tick(1'b1, p3, 1'b0);
        check("full_rdy", 32'(bus.in_ready), 32'd0);
        tick(1'b1, xm, 1'b0);
        check("full_rdy_hold", 32'(bus.in_ready), 32'd0);
        check("full_head", 32'(bus.out_flit), 32'(p0));
        tick(1'b1, xm, 1'b1);
        check("full_rdy_after_pop", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 5; i++) tick(1'b0, 16'h0, 1'b1);
        check("full_drained_v", 32'(bus.out_valid), 32'd0);
        check("full_drained_addr", 32'(bus.table_addr), 32'd0);
        set_exp(0, p0, 3'd0, 5);
        set_exp(1, p1, 3'd0, 6);
        set_exp(2, p2, 3'd0, 7);
        set_exp(3, p3, 3'd0, 8);
        check_stream("full", 4);

        // Orphan body flit after reset: dropped, sticky error
        do_reset();
        start_test();
        tick(1'b1, bo, 1'b1);
        check("drop_addr", 32'(bus.table_addr), 32'd2);
        check("drop_err_early", 32'(bus.err), 32'd0);
        tick(1'b0, 16'h0, 1'b1);
        check("drop_err", 32'(bus.err), 32'd1);
        check("drop_empty", 32'(bus.table_addr), 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0, 1'b1);
        check("drop_nv", 32'(bus.out_valid), 32'd0);
        check_stream("drop", 0);
        start_test();
        tick(1'b1, s5, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0, 1'b1);
        set_exp(0, s5, 3'd4, 2);
        check_stream("drop_next", 1);
        check("drop_err_sticky", 32'(bus.err), 32'd1);

        // Out-of-range table reply: error, still forwarded with dir 6
        do_reset();
        check("bad_rst_err", 32'(bus.err), 32'd0);
        force6 = 1'b1;
        start_test();
        tick(1'b1, s9, 1'b1);
        tick(1'b0, 16'h0, 1'b1);
        check("bad_err", 32'(bus.err), 32'd1);
        force6 = 1'b0;
        for (int i = 0; i < 2; i++) tick(1'b0, 16'h0, 1'b1);
        set_exp(0, s9, 3'd6, 2);
        check_stream("bad", 1);

        // Reset mid-packet flushes everything; next packet routed west
        do_reset();
        start_test();
        tick(1'b1, h9r, 1'b0);
        tick(1'b1, b9r, 1'b0);
        tick(1'b0, 16'h0, 1'b0);
        check("mid_v", 32'(bus.out_valid), 32'd1);
        check("mid_dir", 32'(bus.out_dir), 32'd2);
        do_reset();
        check_reset_outputs("mid_rst");
        start_test();
        tick(1'b1, h4, 1'b1);
        tick(1'b1, t4, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0, 1'b1);
        set_exp(0, h4, 3'd3, 2);
        set_exp(1, t4, 3'd3, 3);
        check_stream("west", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
